// File: rtl/ap_pkg.sv
// Shared definitions for the associative-processor core: opcodes, FSM states,
// CAM select encodings and a constant-evaluable clog2.
package ap_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Main-word CAM select.
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // One-hot internal-column select; zero means "main word".
  localparam logic [2:0] INT_NONE = 3'b000;
  localparam logic [2:0] INT_A    = 3'b001;
  localparam logic [2:0] INT_B    = 3'b010;
  localparam logic [2:0] INT_C    = 3'b100;

  // Opcodes 6..15 are reserved and leave the arrays untouched.
  function automatic logic op_valid(input logic [3:0] cmd);
    return cmd <= OP_NOT;
  endfunction

endpackage

// File: rtl/ap_cell_alu.sv
// One-bit slice: full adder for ADD/SUB (SUB inverts b), bitwise logic otherwise.
module ap_cell_alu
  import ap_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] cmd,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  assign b_eff = (cmd == OP_SUB) ? ~b : b;

  // Result and carry for the selected opcode; logic ops clear the carry.
  always_comb begin
    r    = a;
    cout = cin;
    case (cmd)
      OP_ADD, OP_SUB: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_AND: begin r = a & b; cout = 1'b0; end
      OP_OR:  begin r = a | b; cout = 1'b0; end
      OP_XOR: begin r = a ^ b; cout = 1'b0; end
      OP_NOT: begin r = ~a;    cout = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ap_core.sv
// Associative-processor core: three CAM arrays A, B, C with a per-cell
// internal carry column, a host read/write port and a SIMD A-op-B engine that
// runs either bit-serially over all cells or word-serially over one cell.
module ap_core
  import ap_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 128,
  parameter int ADDR_W     = clog2(CELL_QUANT * 6)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [31:0]          data_in,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [1:0]           sel_col,
  input  logic [2:0]           sel_internal_col,
  input  logic                 op_direction,
  input  logic                 op_target,
  input  logic                 ap_mode,
  input  logic [3:0]           cmd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ap_state_irq
);

  localparam int IDX_W  = clog2(CELL_QUANT);
  localparam int BIT_W  = (WORD_SIZE > 1) ? clog2(WORD_SIZE) : 1;
  localparam int STEP_W = (IDX_W > BIT_W) ? IDX_W : BIT_W;
  localparam logic [STEP_W-1:0] LAST_V = STEP_W'(WORD_SIZE - 1);
  localparam logic [STEP_W-1:0] LAST_H = STEP_W'(CELL_QUANT - 1);

  typedef logic [CELL_QUANT-1:0][WORD_SIZE-1:0] cam_t;

  cam_t a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CELL_QUANT-1:0] a_int_q, a_int_d, b_int_q, b_int_d, c_int_q, c_int_d;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              target_q, target_d;
  logic              dir_q, dir_d;

  logic [IDX_W-1:0]     host_idx;
  logic [IDX_W-1:0]     run_cell;
  logic [BIT_W-1:0]     run_bit;
  logic [WORD_SIZE-1:0] wdata;
  logic [CELL_QUANT-1:0] tgt_int;
  logic                 last_step;

  assign host_idx  = addr_in[IDX_W-1:0];
  assign wdata     = data_in[WORD_SIZE-1:0];
  assign run_cell  = step_q[IDX_W-1:0];
  assign run_bit   = step_q[BIT_W-1:0];
  assign tgt_int   = target_q ? a_int_q : c_int_q;
  assign last_step = dir_q ? (step_q == LAST_H) : (step_q == LAST_V);

  logic unused_bits;
  assign unused_bits = ^{addr_in[ADDR_W-1:IDX_W], data_in[31:WORD_SIZE]};

  // Vertical datapath: one slice per cell at the current bit position.
  logic [CELL_QUANT-1:0] v_r, v_cout;
  for (genvar i = 0; i < CELL_QUANT; i++) begin : g_v
    ap_cell_alu u_alu (
      .a   (a_q[i][run_bit]),
      .b   (b_q[i][run_bit]),
      .cin (tgt_int[i]),
      .cmd (cmd_q),
      .r   (v_r[i]),
      .cout(v_cout[i])
    );
  end

  // Horizontal datapath: a ripple chain across the word of the current cell.
  logic [WORD_SIZE-1:0] h_a, h_b, h_r;
  logic                 h_cin0, h_cout;
  assign h_a    = a_q[run_cell];
  assign h_b    = b_q[run_cell];
  assign h_cin0 = tgt_int[run_cell];

  for (genvar j = 0; j < WORD_SIZE; j++) begin : g_h
    logic cin;
    logic cout;
    if (j == 0) begin : g_first
      assign cin = h_cin0;
    end else begin : g_next
      assign cin = g_h[j-1].cout;
    end
    ap_cell_alu u_alu (
      .a   (h_a[j]),
      .b   (h_b[j]),
      .cin (cin),
      .cmd (cmd_q),
      .r   (h_r[j]),
      .cout(cout)
    );
  end
  assign h_cout = g_h[WORD_SIZE-1].cout;

  // State, operation latches and the arrays themselves.
  // NOTE: the arrays are ordinary flops with async reset because reset must
  // clear every word and carry bit, which a RAM macro could not do.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      cmd_q    <= '0;
      target_q <= 1'b0;
      dir_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      a_int_q  <= '0;
      b_int_q  <= '0;
      c_int_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values, which
      // is what lets A be read and rewritten within the same step.
      state_q  <= state_d;
      step_q   <= step_d;
      cmd_q    <= cmd_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      a_int_q  <= a_int_d;
      b_int_q  <= b_int_d;
      c_int_q  <= c_int_d;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE, with operand latching.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d  = state_q;
    step_d   = step_q;
    cmd_d    = cmd_q;
    target_d = target_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: begin
        if (ap_mode) begin
          state_d  = RUN;
          step_d   = '0;
          cmd_d    = cmd;
          target_d = op_target;
          dir_d    = op_direction;
        end
      end
      RUN: begin
        step_d = step_q + STEP_W'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (!ap_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array updates: host writes and carry seeding in IDLE, one step per RUN edge.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    a_int_d = a_int_q;
    b_int_d = b_int_q;
    c_int_d = c_int_q;
    case (state_q)
      IDLE: begin
        if (write_en) begin
          case (sel_internal_col)
            INT_NONE: begin
              case (sel_col)
                SEL_A:   a_d[host_idx] = wdata;
                SEL_B:   b_d[host_idx] = wdata;
                SEL_C:   c_d[host_idx] = wdata;
                default: ;
              endcase
            end
            INT_A:   a_int_d[host_idx] = data_in[0];
            INT_B:   b_int_d[host_idx] = data_in[0];
            INT_C:   c_int_d[host_idx] = data_in[0];
            default: ;
          endcase
        end
        // The target carry column starts at 1 for SUB (the +1 of A+~B+1).
        if (ap_mode && op_valid(cmd)) begin
          if (op_target) a_int_d = {CELL_QUANT{cmd == OP_SUB}};
          else           c_int_d = {CELL_QUANT{cmd == OP_SUB}};
        end
      end
      RUN: begin
        if (op_valid(cmd_q)) begin
          if (!dir_q) begin
            for (int i = 0; i < CELL_QUANT; i++) begin
              if (target_q) a_d[i][run_bit] = v_r[i];
              else          c_d[i][run_bit] = v_r[i];
            end
            if (target_q) a_int_d = v_cout;
            else          c_int_d = v_cout;
          end else if (target_q) begin
            a_d[run_cell]     = h_r;
            a_int_d[run_cell] = h_cout;
          end else begin
            c_d[run_cell]     = h_r;
            c_int_d[run_cell] = h_cout;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: completion flag and the combinational host read mux.
  always_comb begin
    ap_state_irq = (state_q == DONE);
    data_out     = '0;
    if (read_en && (sel_col != SEL_NONE)) begin
      case (sel_internal_col)
        INT_NONE: begin
          case (sel_col)
            SEL_A:   data_out = a_q[host_idx];
            SEL_B:   data_out = b_q[host_idx];
            SEL_C:   data_out = c_q[host_idx];
            default: ;
          endcase
        end
        INT_A:   data_out = WORD_SIZE'(a_int_q[host_idx]);
        INT_B:   data_out = WORD_SIZE'(b_int_q[host_idx]);
        INT_C:   data_out = WORD_SIZE'(c_int_q[host_idx]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_core.sv
// Directed bench for ap_core: host port, ADD/SUB/XOR in both directions,
// latency, write lockout during RUN, async reset and select corner cases.
module tb_ap_core;

  localparam int ADDR_W = 10;

  logic              clock;
  logic              rst;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       data_in;
  logic              write_en;
  logic              read_en;
  logic [1:0]        sel_col;
  logic [2:0]        sel_internal_col;
  logic              op_direction;
  logic              op_target;
  logic              ap_mode;
  logic [3:0]        cmd;
  logic [7:0]        data_out;
  logic              ap_state_irq;

  int errors = 0;
  int checks = 0;

  ap_core dut (
    .clock           (clock),
    .rst             (rst),
    .addr_in         (addr_in),
    .data_in         (data_in),
    .write_en        (write_en),
    .read_en         (read_en),
    .sel_col         (sel_col),
    .sel_internal_col(sel_internal_col),
    .op_direction    (op_direction),
    .op_target       (op_target),
    .ap_mode         (ap_mode),
    .cmd             (cmd),
    .data_out        (data_out),
    .ap_state_irq    (ap_state_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wr(input logic [1:0] sc, input logic [2:0] ic, input int idx, input logic [31:0] d);
    @(negedge clock);
    sel_col = sc; sel_internal_col = ic; addr_in = ADDR_W'(idx); data_in = d; write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sc, input logic [2:0] ic, input int idx, output logic [7:0] v);
    @(negedge clock);
    sel_col = sc; sel_internal_col = ic; addr_in = ADDR_W'(idx); read_en = 1'b1;
    #1 v = data_out;
    read_en = 1'b0;
  endtask

  task automatic start_op(input logic [3:0] c, input logic dir, input logic tgt);
    @(negedge clock);
    cmd = c; op_direction = dir; op_target = tgt; ap_mode = 1'b1;
  endtask

  // Counts edges from the start edge (1) until irq; scrambles op inputs after start.
  task automatic wait_done(input int expected, input string name);
    int got;
    got = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) begin cmd = 4'hE; op_target = ~op_target; op_direction = ~op_direction; end
      if (ap_state_irq) begin got = n; break; end
    end
    checks++;
    if (got !== expected) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d (0 = timeout)", name, got, expected);
    end
  endtask

  task automatic drop_mode(input string name);
    @(negedge clock);
    ap_mode = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (ap_state_irq !== 1'b0) begin
      errors++;
      $display("FAIL %s irq after drop: got %b, expected 0", name, ap_state_irq);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0; addr_in = '0; data_in = '0; write_en = 0; read_en = 0; sel_col = 0;
    sel_internal_col = 0; op_direction = 0; op_target = 0; ap_mode = 0; cmd = 0;
    #23;
    checks++; if (ap_state_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, expected 0", ap_state_irq); end
    @(negedge clock) rst = 1'b1;
    rd(2'd0, 3'b000, 0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_a0: got %h, expected 00", v); end
    rd(2'd2, 3'b100, 127, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_cint127: got %h, expected 00", v); end
  endtask

  task automatic test_write_read();
    logic [7:0] v;
    wr(2'd0, 3'b000, 5, 32'h0000_002F);
    wr(2'd1, 3'b000, 5, 32'hFFFF_FF11);
    rd(2'd0, 3'b000, 5, v);
    checks++; if (v !== 8'h2F) begin errors++; $display("FAIL wr_a5: got %h, expected 2f", v); end
    rd(2'd1, 3'b000, 5, v);
    checks++; if (v !== 8'h11) begin errors++; $display("FAIL wr_b5: got %h, expected 11", v); end
    rd(2'd0, 3'b001, 5, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wr_aint5: got %h, expected 00", v); end
    // Simultaneous write and read: old value before the edge, new after.
    wr(2'd0, 3'b000, 9, 32'h12);
    @(negedge clock);
    sel_col = 2'd0; sel_internal_col = 3'b000; addr_in = ADDR_W'(9); data_in = 32'h34;
    write_en = 1'b1; read_en = 1'b1;
    #1;
    checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL wr_rd_old: got %h, expected 12", data_out); end
    @(posedge clock); #1;
    write_en = 1'b0;
    checks++; if (data_out !== 8'h34) begin errors++; $display("FAIL wr_rd_new: got %h, expected 34", data_out); end
    read_en = 1'b0;
  endtask

  task automatic test_add_vertical();
    logic [7:0] v;
    wr(2'd0, 3'b000, 0, 32'hF0);
    wr(2'd1, 3'b000, 0, 32'h20);
    wr(2'd0, 3'b000, 1, 32'h03);
    wr(2'd1, 3'b000, 1, 32'h04);
    start_op(4'd0, 1'b0, 1'b0);
    wait_done(9, "add_v");
    rd(2'd2, 3'b000, 0, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL add_c0: got %h, expected 10", v); end
    rd(2'd2, 3'b100, 0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL add_cint0: got %h, expected 01", v); end
    rd(2'd2, 3'b000, 1, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL add_c1: got %h, expected 07", v); end
    rd(2'd2, 3'b100, 1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL add_cint1: got %h, expected 00", v); end
    rd(2'd0, 3'b000, 0, v);
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL add_a0_kept: got %h, expected f0", v); end
    drop_mode("add_v");
  endtask

  task automatic test_sub();
    logic [7:0] v;
    wr(2'd0, 3'b000, 7, 32'h05);
    wr(2'd1, 3'b000, 7, 32'h09);
    start_op(4'd1, 1'b1, 1'b1);
    wait_done(129, "sub_h");
    rd(2'd0, 3'b000, 7, v);
    checks++; if (v !== 8'hFC) begin errors++; $display("FAIL sub_h_a7: got %h, expected fc", v); end
    rd(2'd0, 3'b001, 7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sub_h_aint7: got %h, expected 00", v); end
    rd(2'd0, 3'b000, 0, v);
    checks++; if (v !== 8'hD0) begin errors++; $display("FAIL sub_h_a0: got %h, expected d0", v); end
    drop_mode("sub_h");
    wr(2'd0, 3'b000, 7, 32'h05);
    start_op(4'd1, 1'b0, 1'b1);
    wait_done(9, "sub_v");
    rd(2'd0, 3'b000, 7, v);
    checks++; if (v !== 8'hFC) begin errors++; $display("FAIL sub_v_a7: got %h, expected fc", v); end
    rd(2'd0, 3'b001, 7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sub_v_aint7: got %h, expected 00", v); end
    // A5: 2F-11=1E (horizontal), then 1E-11=0D with no borrow.
    rd(2'd0, 3'b000, 5, v);
    checks++; if (v !== 8'h0D) begin errors++; $display("FAIL sub_v_a5: got %h, expected 0d", v); end
    rd(2'd0, 3'b001, 5, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL sub_v_aint5: got %h, expected 01", v); end
    drop_mode("sub_v");
  endtask

  task automatic test_xor();
    logic [7:0] v;
    wr(2'd0, 3'b000, 2, 32'hAA);
    wr(2'd1, 3'b000, 2, 32'h0F);
    start_op(4'd4, 1'b0, 1'b0);
    wait_done(9, "xor");
    rd(2'd2, 3'b000, 2, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL xor_c2: got %h, expected a5", v); end
    rd(2'd2, 3'b100, 0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL xor_cint0_cleared: got %h, expected 00", v); end
    drop_mode("xor");
  endtask

  task automatic test_run_lockout();
    logic [7:0] v;
    start_op(4'd0, 1'b0, 1'b0);
    @(negedge clock);
    sel_col = 2'd1; sel_internal_col = 3'b000; addr_in = ADDR_W'(3); data_in = 32'h55; write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
    wait_done(7, "lockout");
    rd(2'd1, 3'b000, 3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL lockout_b3: got %h, expected 00", v); end
    drop_mode("lockout");
    // Abort a horizontal op with an asynchronous reset pulse.
    start_op(4'd4, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #2 rst = 1'b0;
    #1;
    checks++; if (ap_state_irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b, expected 0", ap_state_irq); end
    ap_mode = 1'b0;
    rd(2'd0, 3'b000, 5, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_a5: got %h, expected 00", v); end
    rd(2'd2, 3'b000, 2, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_c2: got %h, expected 00", v); end
    rd(2'd1, 3'b000, 7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_b7: got %h, expected 00", v); end
    @(negedge clock) rst = 1'b1;
    wr(2'd0, 3'b000, 4, 32'h33);
    rd(2'd0, 3'b000, 4, v);
    checks++; if (v !== 8'h33) begin errors++; $display("FAIL abort_idle_write: got %h, expected 33", v); end
    checks++; if (ap_state_irq !== 1'b0) begin errors++; $display("FAIL abort_irq_after: got %b, expected 0", ap_state_irq); end
  endtask

  task automatic test_select();
    logic [7:0] v;
    wr(2'd3, 3'b000, 4, 32'hFF);
    rd(2'd0, 3'b000, 4, v);
    checks++; if (v !== 8'h33) begin errors++; $display("FAIL sel3_a4: got %h, expected 33", v); end
    rd(2'd1, 3'b000, 4, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sel3_b4: got %h, expected 00", v); end
    rd(2'd2, 3'b000, 4, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sel3_c4: got %h, expected 00", v); end
    rd(2'd3, 3'b000, 4, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sel3_read: got %h, expected 00", v); end
    wr(2'd0, 3'b001, 6, 32'h1);
    rd(2'd0, 3'b001, 6, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL int_a6: got %h, expected 01", v); end
    rd(2'd0, 3'b011, 6, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL int_not_onehot: got %h, expected 00", v); end
    @(negedge clock);
    sel_col = 2'd0; sel_internal_col = 3'b000; addr_in = ADDR_W'(4); read_en = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL read_en_low: got %h, expected 00", data_out); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_add_vertical();
    test_sub();
    test_xor();
    test_run_lockout();
    test_select();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_core.md
Name: ap_core

Overview:
- Associative-processor (AP) core with three CAM word arrays, A, B and C.
- Each array holds CELL_QUANT words of WORD_SIZE bits, plus one 1-bit internal column per cell (carry/flag).
- Host side reads and writes the arrays through a simple memory port. A trigger launches a SIMD operation, A op B, with the result written to C or to A.
- Sits under the memory-mapped AP wrapper, which drives the mode/settings registers.

Parameters:
- WORD_SIZE, 8, bits per CAM word.
- CELL_QUANT, 128, cells per CAM; power of two.
- ADDR_W, clog2(CELL_QUANT*6), width of addr_in.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset; the wrapper drives its LSB.
- addr_in  in  ADDR_W  host address; only bits [clog2(CELL_QUANT)-1:0] (cell index) are used.
- data_in  in  32  write data; low WORD_SIZE bits used.
- write_en  in  1  host write strobe.
- read_en  in  1  host read enable.
- sel_col  in  2  CAM select: 0=A, 1=B, 2=C, 3=none.
- sel_internal_col  in  3  one-hot internal-column select: 001=A, 010=B, 100=C, 000=main word.
- op_direction  in  1  0=vertical (bit-serial, all cells parallel); 1=horizontal (word-serial, one cell per cycle).
- op_target  in  1  0: C = A op B; 1: A = A op B.
- ap_mode  in  1  level trigger for computation.
- cmd  in  4  opcode.
- data_out  out  WORD_SIZE  read data.
- ap_state_irq  out  1  operation-complete flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - all array words and internal bits are 0;
  - state is IDLE;
  - ap_state_irq=0.
  - Reset during RUN aborts the operation; array contents are cleared.
- Read (combinational):
  - data_out = internal bit of the selected CAM (zero-extended) if sel_internal_col≠0;
  - otherwise the main word of CAM sel_col at the cell index;
  - data_out = 0 if read_en=0, sel_col=3, or sel_internal_col is not one-hot.
  - Reads are allowed in every state.
- Write (synchronous, rising edge):
  - Occurs only in IDLE with write_en=1.
  - Target is the same as for read; an internal-column write stores data_in[0].
  - Writes are ignored in RUN and DONE, and when sel_col=3 with sel_internal_col=0.
  - If write_en and read_en are both high, the write wins; data_out shows the old value.
- Opcodes:
  - 0 ADD: result = A+B mod 2^WORD_SIZE; carry-out goes to the internal column of the target CAM.
  - 1 SUB: result = A+~B+1; carry-out (1 = no borrow) goes to the internal column of the target CAM.
  - 2 AND, 3 OR, 4 XOR: bitwise; the target's internal column is cleared.
  - 5 NOT: result = ~A; the target's internal column is cleared.
  - 6-15: reserved; no array change, completes with normal latency.
- State machine IDLE→RUN→DONE→IDLE:
  - IDLE with ap_mode=1 at an edge:
    - latch cmd, op_target and op_direction;
    - step counter = 0;
    - target internal column = 1 for SUB, 0 otherwise;
    - go to RUN.
  - RUN, vertical: each edge processes bit position k (LSB first) for all cells in parallel. The internal column is the running carry.
  - RUN, horizontal: each edge processes the full word of cell k.
  - The edge processing the last step (k = WORD_SIZE-1 vertical, k = CELL_QUANT-1 horizontal) moves to DONE.
  - DONE: ap_state_irq=1. State holds while ap_mode=1; ap_mode=0 returns to IDLE and clears the irq on the same edge.
- Latency: irq rises WORD_SIZE+1 edges (vertical) or CELL_QUANT+1 edges (horizontal) after the start edge, counting the start edge.
  - Vertical and horizontal modes give bit-identical results.
- Input changes to cmd, op_target, op_direction or sel_* during RUN have no effect on the running operation.
- ap_mode dropping during RUN does not abort; the core goes to IDLE on the first edge in DONE.
- When op_target=1, A is both source and destination. Each step reads operand bits before the write of that same step.

Decomposition:
- Package ap_pkg holds:
  - opcode constants (ADD..NOT);
  - state enum {IDLE, RUN, DONE};
  - CAM-select encodings;
  - a clog2 function.
- One sub-module, ap_cell_alu: 1-bit full-adder/logic slice (a, b, cin, cmd → r, cout). It is instantiated per cell for vertical mode and in a WORD_SIZE-wide chain for horizontal mode.

Test Plan:
- Write A[5]=0x2F and B[5]=0x11; read back each word and the internal bit of A → 0x2F, 0x11, 0.
- ADD, vertical, op_target=0, with A[0]=0xF0, B[0]=0x20, A[1]=3, B[1]=4:
  - irq is high exactly 9 edges after start, counting the start edge;
  - C[0]=0x10 with C internal[0]=1;
  - C[1]=7 with C internal[1]=0.
- SUB, horizontal, op_target=1, with A[7]=5, B[7]=9:
  - irq is high after 129 edges;
  - A[7]=0xFC with A internal[7]=0.
  - Repeat vertical → identical result after 9 edges.
- XOR with A[2]=0xAA, B[2]=0x0F → C[2]=0xA5. Drop ap_mode → irq=0 next edge.
- Write attempted during RUN → ignored, array unchanged. Pulse rst low mid-RUN → state IDLE, irq=0, all reads 0.
- Select checks:
  - sel_col=3 → data_out=0 and writes ignored;
  - sel_internal_col=011 → data_out=0.
